// File: rtl/uart_tx_parity_if.sv
// Handshake and serial-line bundle between the TX FIFO / command layer and the UART transmitter.
// The master drives the request and the baud tick; the transmitter (slave) returns line and status.
interface uart_tx_parity_if;
    logic       tx_start;
    logic       s_tick;
    logic [7:0] din;
    logic       tx;
    logic       tx_busy;
    logic       tx_done_tick;

    modport master (
        output tx_start,
        output s_tick,
        output din,
        input  tx,
        input  tx_busy,
        input  tx_done_tick
    );

    modport slave (
        input  tx_start,
        input  s_tick,
        input  din,
        output tx,
        output tx_busy,
        output tx_done_tick
    );
endinterface

// File: rtl/uart_tx_parity.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional even/odd parity, SB_TICK-long stop.
// Bit timing comes from a 16x oversampling tick; tx and tx_busy are registered, tx_done_tick is Mealy.
module uart_tx_parity #(
    parameter int DBIT    = 8,
    parameter int PARITY  = 0,
    parameter int SB_TICK = 16
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_parity_if.slave    bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    localparam bit         HAS_PAR   = (PARITY == 1) || (PARITY == 2);
    localparam bit         ODD_PAR   = (PARITY == 2);
    localparam logic [4:0] S_LAST    = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
    localparam logic [7:0] DMASK     = 8'hFF >> (8 - DBIT);

    state_t     state_q, state_d;
    logic [4:0] s_q, s_d;
    logic [2:0] n_q, n_d;
    logic [7:0] b_q, b_d;
    logic       par_q, par_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       done;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        par_d   = par_q;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.tx_start) begin
                    b_d     = bus.din;
                    par_d   = (^(bus.din & DMASK)) ^ ODD_PAR;
                    s_d     = 5'd0;
                    state_d = START;
                end
            end
            START: begin
                if (bus.s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = 5'd0;
                        n_d     = 3'd0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = 5'd0;
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = HAS_PAR ? PAR : STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            PAR: begin
                if (bus.s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = 5'd0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (bus.s_tick) begin
                    if (s_q == STOP_LAST) begin
                        s_d     = 5'd0;
                        state_d = IDLE;
                        done    = 1'b1;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level follows the state being entered so tx flips on the same edge as the transition.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            PAR:     tx_d = par_q;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= 5'd0;
            n_q     <= 3'd0;
            b_q     <= 8'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.tx           = tx_q;
    assign bus.tx_busy      = busy_q;
    assign bus.tx_done_tick = done;
endmodule

// File: tb/tb_uart_tx_parity.sv
// Directed vector bench for uart_tx_parity across 8N1, 8E1, 8O1 and 7-bit/2-stop builds.
// Each frame is checked mid-bit against a hand-written line pattern plus tick/cycle timing.
module tb_uart_tx_parity;
    logic       clk;
    logic       reset;
    logic       tx_start_v;
    logic       s_tick_v;
    logic [7:0] din_v;
    int         sel;
    int         tick_mode;
    int         div;
    logic       tx_m, busy_m, done_m;

    int nchk;
    int nerr;

    uart_tx_parity_if bus0 ();
    uart_tx_parity_if bus1 ();
    uart_tx_parity_if bus2 ();
    uart_tx_parity_if bus3 ();

    assign bus0.tx_start = tx_start_v && (sel == 0);
    assign bus1.tx_start = tx_start_v && (sel == 1);
    assign bus2.tx_start = tx_start_v && (sel == 2);
    assign bus3.tx_start = tx_start_v && (sel == 3);
    assign bus0.s_tick = s_tick_v;
    assign bus1.s_tick = s_tick_v;
    assign bus2.s_tick = s_tick_v;
    assign bus3.s_tick = s_tick_v;
    assign bus0.din = din_v;
    assign bus1.din = din_v;
    assign bus2.din = din_v;
    assign bus3.din = din_v;

    uart_tx_parity #(.DBIT(8), .PARITY(0), .SB_TICK(16)) u_8n1 (.clk(clk), .reset(reset), .bus(bus0.slave));
    uart_tx_parity #(.DBIT(8), .PARITY(1), .SB_TICK(16)) u_8e1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    uart_tx_parity #(.DBIT(8), .PARITY(2), .SB_TICK(16)) u_8o1 (.clk(clk), .reset(reset), .bus(bus2.slave));
    uart_tx_parity #(.DBIT(7), .PARITY(0), .SB_TICK(32)) u_7n2 (.clk(clk), .reset(reset), .bus(bus3.slave));

    always_comb begin
        tx_m   = bus0.tx;
        busy_m = bus0.tx_busy;
        done_m = bus0.tx_done_tick;
        case (sel)
            1: begin tx_m = bus1.tx; busy_m = bus1.tx_busy; done_m = bus1.tx_done_tick; end
            2: begin tx_m = bus2.tx; busy_m = bus2.tx_busy; done_m = bus2.tx_done_tick; end
            3: begin tx_m = bus3.tx; busy_m = bus3.tx_busy; done_m = bus3.tx_done_tick; end
            default: ;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud tick: mode 0 none, 1 one clk in four, 2 held high.
    initial begin
        s_tick_v = 1'b0;
        div = 0;
        forever begin
            @(posedge clk);
            #2;
            div = (div + 1) % 4;
            s_tick_v = (tick_mode == 2) ? 1'b1 : ((tick_mode == 1) ? (div == 0) : 1'b0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          sel;
        int          mode;
        logic [7:0]  din;
        logic [10:0] line;
        int          nb;
        int          ticks;
        int          done_cyc;
        int          rise_cyc;
        bit          inj;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Entered and left at a negedge; returns in the idle cycle right after the done pulse.
    task automatic run_frame(input vec_t v);
        int cyc, ticks, dones, done_ticks, done_cyc, rise, idx, pos;
        bit fin;
        cyc = 0; ticks = 0; dones = 0; done_ticks = 0; done_cyc = 0; rise = 0; fin = 0;
        sel = v.sel;
        tick_mode = v.mode;
        din_v = v.din;
        tx_start_v = 1'b1;
        @(posedge clk);
        while (!fin && cyc < 1200) begin
            @(negedge clk);
            cyc++;
            tx_start_v = 1'b0;
            if (cyc == 1) begin
                din_v = ~v.din;
                chk("accept_tx", tx_m, 0);
                chk("accept_busy", busy_m, 1);
            end
            if (rise == 0 && tx_m === 1'b1 && dones == 0) rise = cyc;
            if (dones > 0 && cyc == done_cyc + 1) begin
                chk("post_busy", busy_m, 0);
                chk("post_tx", tx_m, 1);
                chk("post_done", done_m, 0);
                fin = 1;
            end else begin
                if (s_tick_v) begin
                    idx = ticks / 16;
                    pos = ticks % 16;
                    if (pos == 7) begin
                        if (idx < v.nb) chk($sformatf("bit%0d", idx), tx_m, v.line[idx]);
                        else            chk("stop_bit", tx_m, 1);
                    end
                    if (v.inj && ticks == 52) begin
                        tx_start_v = 1'b1;
                        din_v = 8'hAA;
                    end
                    ticks++;
                end
                if (done_m) begin
                    dones++;
                    done_ticks = ticks;
                    done_cyc = cyc;
                    if (v.inj) begin
                        tx_start_v = 1'b1;
                        din_v = 8'hAA;
                    end
                end
            end
        end
        chk("done_count", dones, 1);
        chk("frame_ticks", done_ticks, v.ticks);
        if (v.done_cyc != 0) chk("done_cycle", done_cyc, v.done_cyc);
        if (v.rise_cyc != 0) chk("first_rise", rise, v.rise_cyc);
    endtask

    initial begin
        int cyc, ticks;
        nchk = 0;
        nerr = 0;
        sel = 0;
        tick_mode = 1;
        tx_start_v = 1'b0;
        din_v = 8'h00;
        reset = 1'b1;

        //                sel mode din    line (bit i = i-th line bit)  nb  ticks dcyc rise inj
        vecs[0] = '{0, 1, 8'h55, 11'b00010101010,  9, 160,   0,   0, 1'b0};
        vecs[1] = '{1, 1, 8'h07, 11'b01000001110, 10, 176,   0,   0, 1'b0};
        vecs[2] = '{2, 1, 8'h07, 11'b00000001110, 10, 176,   0,   0, 1'b0};
        vecs[3] = '{3, 1, 8'hFF, 11'b00011111110,  8, 160,   0,   0, 1'b0};
        vecs[4] = '{3, 1, 8'h80, 11'b00000000000,  8, 160,   0,   0, 1'b0};
        vecs[5] = '{2, 1, 8'h00, 11'b01000000000, 10, 176,   0,   0, 1'b0};
        vecs[6] = '{0, 2, 8'h80, 11'b00100000000,  9, 160, 160, 129, 1'b0};
        vecs[7] = '{0, 1, 8'h55, 11'b00010101010,  9, 160,   0,   0, 1'b1};
        vecs[8] = '{0, 1, 8'h3C, 11'b00001111000,  9, 160,   0,   0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_tx0", bus0.tx, 1);
        chk("rst_busy0", bus0.tx_busy, 0);
        chk("rst_done0", bus0.tx_done_tick, 0);
        chk("rst_tx3", bus3.tx, 1);
        chk("rst_busy1", bus1.tx_busy, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_tx2", bus2.tx, 1);
        chk("idle_busy2", bus2.tx_busy, 0);

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i]);
            repeat (3) @(negedge clk);
        end
        // Ignored starts mid-data and on the done cycle, then a back-to-back frame.
        run_frame(vecs[7]);
        run_frame(vecs[8]);
        repeat (3) @(negedge clk);

        // Reset in the middle of the third data bit of 0x5A (that bit is 0).
        sel = 0;
        tick_mode = 1;
        din_v = 8'h5A;
        tx_start_v = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_start_v = 1'b0;
        cyc = 0;
        ticks = 0;
        while (ticks < 56 && cyc < 1000) begin
            if (s_tick_v) ticks++;
            @(negedge clk);
            cyc++;
        end
        chk("mid_data_tx", tx_m, 0);
        chk("mid_data_busy", busy_m, 1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_tx", tx_m, 1);
        chk("async_rst_busy", busy_m, 0);
        chk("async_rst_done", done_m, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_hold_done", done_m, 0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rel_tx", tx_m, 1);
        chk("rel_busy", busy_m, 0);
        run_frame(vecs[8]);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule
